uart_rx: RTL and testbench

//   UART receiver, counterpart of the existing tx block, sharing the same baudRateGenerator tick (16x oversampling).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync_2ff.sv | 30 +++
 rtl/uart_rx.sv | 169 ++++++++++++++++
 tb/tb_uart_rx.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART blocks: FSM state encoding and the
// oversampling points used by the receiver.
//   OVERSAMPLE : ticks per bit (baud generator runs at 16x)
//   MID_START  : tick index at which the start bit is re-checked
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int MID_START  = 7;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

endpackage

// File: rtl/uart_sync_2ff.sv
// ----------------------------------------------------------------------------
// uart_sync_2ff
// Two-flop synchronizer for a single asynchronous input. Both flops reset to 1
// so an idle-high serial line does not look like a start bit after reset.
// Ports:
//   i_clk   : system clock
//   i_reset : asynchronous, active-low reset
//   i_async : asynchronous input
//   o_sync  : synchronized output (2 clock latency)
// ----------------------------------------------------------------------------
module uart_sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_async,
    output logic o_sync
);

    logic meta;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            meta   <= 1'b1;
            o_sync <= 1'b1;
        end else begin
            meta   <= i_async;
            o_sync <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver driven by the 16x oversampling tick of the baud generator.
// Reassembles NB_DATA-bit words LSB first and reports framing errors, plus
// parity errors when built with UART_RX_PARITY_EN defined (otherwise the
// frame is start + data + stop and o_parity_err is tied low).
// Parameters:
//   NB_DATA    : data bits per frame (5..9)
//   SB_TICK    : ticks spent in the stop bit (16/24/32)
//   PARITY_ODD : 0 = even, 1 = odd parity (UART_RX_PARITY_EN builds only)
// Ports:
//   i_clk          : system clock
//   i_reset        : asynchronous, active-low reset
//   i_tick         : 1-cycle oversampling strobe
//   i_rx           : serial line, idle high, asynchronous
//   o_data         : last received word, held until the next frame completes
//   o_rx_done_tick : 1-cycle pulse when a frame completes
//   o_frame_err    : stop bit sampled low on the last frame
//   o_parity_err   : parity mismatch on the last frame
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA    = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_rx_done_tick,
    output logic               o_frame_err,
    output logic               o_parity_err
);

    localparam int S_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
    localparam logic [S_W-1:0] S_MID       = S_W'(MID_START);
    localparam logic [S_W-1:0] S_LAST_BIT  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_LAST_STOP = S_W'(SB_TICK - 1);
    localparam logic [3:0]     N_LAST      = 4'(NB_DATA - 1);

    logic               rx_s;
    logic [2:0]         state;
    logic [S_W-1:0]     s_cnt;
    logic [3:0]         n_cnt;
    logic [NB_DATA-1:0] b;

    uart_sync_2ff u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_async (i_rx),
        .o_sync  (rx_s)
    );

`ifdef UART_RX_PARITY_EN
    logic parity_bit;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            parity_bit <= 1'b0;
        end else if (state == ST_PARITY && i_tick && s_cnt == S_LAST_BIT) begin
            parity_bit <= rx_s;
        end
    end
`endif

    // Each state only acts on i_tick (except IDLE/BREAK, which watch the line
    // directly); a tick seen in the cycle of a state change belongs to the
    // state being left.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state          <= ST_IDLE;
            s_cnt          <= '0;
            n_cnt          <= '0;
            b              <= '0;
            o_data         <= '0;
            o_rx_done_tick <= 1'b0;
            o_frame_err    <= 1'b0;
            o_parity_err   <= 1'b0;
        end else begin
            o_rx_done_tick <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        s_cnt <= '0;
                    end
                end
                ST_START: begin
                    if (i_tick) begin
                        if (s_cnt == S_MID) begin
                            // Line high again at mid start bit: treat as glitch.
                            if (!rx_s) begin
                                state <= ST_DATA;
                                s_cnt <= '0;
                                n_cnt <= '0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                ST_DATA: begin
                    if (i_tick) begin
                        if (s_cnt == S_LAST_BIT) begin
                            b     <= {rx_s, b[NB_DATA-1:1]};
                            s_cnt <= '0;
                            if (n_cnt == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                state <= ST_PARITY;
`else
                                state <= ST_STOP;
`endif
                            end else begin
                                n_cnt <= n_cnt + 1'b1;
                            end
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (i_tick) begin
                        if (s_cnt == S_LAST_BIT) begin
                            s_cnt <= '0;
                            state <= ST_STOP;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (i_tick) begin
                        if (s_cnt == S_LAST_STOP) begin
                            o_data         <= b;
                            o_frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            o_parity_err   <= ((^b) ^ parity_bit) != 1'(PARITY_ODD);
`else
                            o_parity_err   <= 1'b0;
`endif
                            o_rx_done_tick <= 1'b1;
                            // A low stop bit means a break or a stuck line;
                            // wait for idle before looking for a new start.
                            state          <= rx_s ? ST_IDLE : ST_BREAK;
                        end else begin
                            s_cnt <= s_cnt + 1'b1;
                        end
                    end
                end
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Directed testbench for uart_rx. The oversampling tick comes from a small
// divider (one tick every TICK_DIV clocks) so that whole frames stay short;
// every bit lasts 16 ticks as with the real baud generator.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int TICK_DIV = 4;
    localparam int BIT_T    = 16;

    logic       clk;
    logic       rst_n;
    logic       tick;
    logic       rx;
    logic [7:0] data;
    logic       done;
    logic       frame_err;
    logic       parity_err;

    int checks = 0;
    int errors = 0;
    int done_count = 0;
    logic [7:0] rx_log[$];
    int tick_div = 0;

    uart_rx #(
        .NB_DATA    (8),
        .SB_TICK    (16),
        .PARITY_ODD (0)
    ) dut (
        .i_clk          (clk),
        .i_reset        (rst_n),
        .i_tick         (tick),
        .i_rx           (rx),
        .o_data         (data),
        .o_rx_done_tick (done),
        .o_frame_err    (frame_err),
        .o_parity_err   (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_div == TICK_DIV - 1) begin
            tick_div <= 0;
            tick     <= 1'b1;
        end else begin
            tick_div <= tick_div + 1;
            tick     <= 1'b0;
        end
    end

    // Record every done pulse and the word presented with it.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count = done_count + 1;
            rx_log.push_back(data);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic wait_ticks(input int n);
        int k = 0;
        while (k < n) begin
            @(negedge clk);
            if (tick === 1'b1) k++;
        end
    endtask

    task automatic send_bit(input logic v, input int nticks);
        rx = v;
        wait_ticks(nticks);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par,
                              input logic stop_v, input int stop_ticks);
        send_bit(1'b0, BIT_T);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_T);
`ifdef UART_RX_PARITY_EN
        send_bit(par, BIT_T);
`else
        if (par !== par) $display("[TB] unreachable");
`endif
        send_bit(stop_v, stop_ticks);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h want 00", data); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_perr got %b want 0", parity_err); end
        rst_n = 1'b1;
        wait_ticks(4);
    endtask

    task automatic test_basic;
        int c0 = done_count;
        send_frame(8'hE5, 1'b1, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (done_count - c0 !== 1) begin errors++; $display("[TB] FAIL basic_done got %0d want 1", done_count - c0); end
        checks++; if (data !== 8'hE5) begin errors++; $display("[TB] FAIL basic_data got %h want e5", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_ferr got %b want 0", frame_err); end
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL basic_perr got %b want 0", parity_err); end
    endtask

    task automatic test_glitch;
        int c0 = done_count;
        send_bit(1'b0, 4);
        send_bit(1'b1, 3 * BIT_T);
        checks++; if (done_count - c0 !== 0) begin errors++; $display("[TB] FAIL glitch_done got %0d want 0", done_count - c0); end
        checks++; if (data !== 8'hE5) begin errors++; $display("[TB] FAIL glitch_data got %h want e5", data); end
    endtask

    task automatic test_break;
        int c0 = done_count;
        send_frame(8'h00, 1'b0, 1'b0, BIT_T + 3 * BIT_T);
        checks++; if (done_count - c0 !== 1) begin errors++; $display("[TB] FAIL break_done got %0d want 1", done_count - c0); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("[TB] FAIL break_ferr got %b want 1", frame_err); end
        checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL break_data got %h want 00", data); end
        send_bit(1'b1, BIT_T);
        checks++; if (done_count - c0 !== 1) begin errors++; $display("[TB] FAIL break_hold got %0d want 1", done_count - c0); end
        send_frame(8'h5A, 1'b0, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (done_count - c0 !== 2) begin errors++; $display("[TB] FAIL break_next_done got %0d want 2", done_count - c0); end
        checks++; if (data !== 8'h5A) begin errors++; $display("[TB] FAIL break_next_data got %h want 5a", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL break_next_ferr got %b want 0", frame_err); end
    endtask

    task automatic test_back_to_back;
        rx_log.delete();
        send_frame(8'h55, 1'b0, 1'b1, BIT_T);
        send_frame(8'hAA, 1'b0, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (rx_log.size() !== 2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", rx_log.size()); end
        if (rx_log.size() >= 2) begin
            checks++; if (rx_log[0] !== 8'h55) begin errors++; $display("[TB] FAIL b2b_first got %h want 55", rx_log[0]); end
            checks++; if (rx_log[1] !== 8'hAA) begin errors++; $display("[TB] FAIL b2b_second got %h want aa", rx_log[1]); end
        end
    endtask

    task automatic test_reset_mid;
        int c0 = done_count;
        send_bit(1'b0, BIT_T);
        for (int i = 0; i < 4; i++) send_bit(1'b1, BIT_T);
        send_bit(1'b1, BIT_T / 2);
        rst_n = 1'b0;
        #1;
        checks++; if (data !== 8'h00) begin errors++; $display("[TB] FAIL rstmid_data got %h want 00", data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_ferr got %b want 0", frame_err); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_done got %b want 0", done); end
        wait_ticks(BIT_T);
        rst_n = 1'b1;
        wait_ticks(BIT_T);
        checks++; if (done_count - c0 !== 0) begin errors++; $display("[TB] FAIL rstmid_nodone got %0d want 0", done_count - c0); end
        send_frame(8'h3C, 1'b0, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (done_count - c0 !== 1) begin errors++; $display("[TB] FAIL rstmid_next_done got %0d want 1", done_count - c0); end
        checks++; if (data !== 8'h3C) begin errors++; $display("[TB] FAIL rstmid_next_data got %h want 3c", data); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        send_frame(8'hE5, 1'b1, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (parity_err !== 1'b0) begin errors++; $display("[TB] FAIL parity_good got %b want 0", parity_err); end
        send_frame(8'hE5, 1'b0, 1'b1, BIT_T);
        wait_ticks(4);
        checks++; if (parity_err !== 1'b1) begin errors++; $display("[TB] FAIL parity_bad got %b want 1", parity_err); end
        checks++; if (data !== 8'hE5) begin errors++; $display("[TB] FAIL parity_data got %h want e5", data); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        rx    = 1'b1;
        tick  = 1'b0;
        test_reset();
        test_basic();
        test_glitch();
        test_break();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
